// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS core front end.
// Latency: none (declarations only).
// Backpressure: not applicable.
package mips_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC selection: jump target, branch target, sequential PC+4 or hold.
// Latency: purely combinational.
// Backpressure: a stall suppresses both redirect and sequential advance.
module pc_next_sel (
    input  logic        stall,
    input  logic        jump,
    input  logic        pcsrc,
    input  logic        advance,
    input  logic [31:0] pc,
    input  logic [31:0] pcbranch,
    input  logic [3:0]  pc_hi,
    input  logic [25:0] jidx,
    output logic        redir,
    output logic [31:0] pc_plus4,
    output logic [31:0] pc_next
);

    // Redirect wins over sequential advance; jump wins over branch.
    // Branch targets are forced word-aligned so the PC low bits stay zero.
    always_comb begin
        redir    = !stall && (jump || pcsrc);
        pc_plus4 = pc + 32'd4;
        pc_next  = pc;
        if (redir) begin
            pc_next = jump ? {pc_hi, jidx, 2'b00} : (pcbranch & ~32'h3);
        end else if (!stall && advance) begin
            pc_next = pc_plus4;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, the imem request FSM and the IF/ID pipeline register.
// Latency: one request outstanding; zero-wait memory yields one instruction per 2 cycles.
// Backpressure: stallD freezes PC and IF/ID; a response arriving under stall is parked in a hold buffer.
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stallD,
    input  logic        pcsrcD,
    input  logic [31:0] pcbranchD,
    input  logic        jumpD,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pcF,
    output logic [31:0] instrD,
    output logic [31:0] pcplus4D,
    output logic        validD,
    output logic [5:0]  opD,
    output logic [5:0]  functD,
    output logic        fetch_busy
);

    fetch_state_t state, state_nxt;
    logic         drop, drop_nxt;
    logic         hold_ld;
    logic [31:0]  hold_buf;
    logic         avail;
    logic [31:0]  instr_src;
    logic         redir;
    logic [31:0]  pc_plus4;
    logic [31:0]  pc_next;

    pc_next_sel u_pc_next_sel (
        .stall    (stallD),
        .jump     (jumpD),
        .pcsrc    (pcsrcD),
        .advance  (avail),
        .pc       (pcF),
        .pcbranch (pcbranchD),
        .pc_hi    (pcplus4D[31:28]),
        .jidx     (instrD[25:0]),
        .redir    (redir),
        .pc_plus4 (pc_plus4),
        .pc_next  (pc_next)
    );

    // Instruction availability and memory-side outputs derived from the FSM state.
    always_comb begin
        imem_req   = (state == REQ);
        imem_addr  = pcF;
        avail      = ((state == WAIT) && imem_rvalid && !drop) || (state == HOLD);
        fetch_busy = !avail;
        instr_src  = (state == HOLD) ? hold_buf : imem_rdata;
    end

    // Next-state logic; drop marks an in-flight response that a redirect has made stale.
    always_comb begin
        state_nxt = state;
        drop_nxt  = drop;
        hold_ld   = 1'b0;
        case (state)
            IDLE: state_nxt = REQ;
            REQ: begin
                if (imem_ready) begin
                    state_nxt = WAIT;
                    if (redir) drop_nxt = 1'b1;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    if (drop) begin
                        drop_nxt  = 1'b0;
                        state_nxt = REQ;
                    end else if (stallD) begin
                        hold_ld   = 1'b1;
                        state_nxt = HOLD;
                    end else begin
                        // Either loaded into IF/ID or discarded by a same-cycle redirect.
                        state_nxt = REQ;
                    end
                end else if (redir) begin
                    drop_nxt = 1'b1;
                end
            end
            HOLD: begin
                if (!stallD) state_nxt = REQ;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, drop flag, hold buffer and PC registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            drop     <= 1'b0;
            hold_buf <= NOP_INSTR;
            pcF      <= RESET_PC;
        end else begin
            state <= state_nxt;
            drop  <= drop_nxt;
            pcF   <= pc_next;
            if (hold_ld) hold_buf <= imem_rdata;
        end
    end

    // IF/ID register: load when an instruction is ready, bubble otherwise, freeze under stall.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instrD   <= NOP_INSTR;
            pcplus4D <= 32'h0;
            validD   <= 1'b0;
        end else if (!stallD) begin
            if (!redir && avail) begin
                instrD   <= instr_src;
                pcplus4D <= pc_plus4;
                validD   <= 1'b1;
            end else begin
                instrD <= NOP_INSTR;
                validD <= 1'b0;
            end
        end
    end

    assign opD    = instrD[31:26];
    assign functD = instrD[5:0];

endmodule
